// File: rtl/vu_level_meter.sv
// Peak-tracking VU meter: converts signed PCM peaks to a lit-LED count once per frame and
// strobes the strip controller. Optional peak hold is built when VU_PEAK_HOLD_EN is defined.
module vu_level_meter #(
  parameter int SAMPLE_W     = 16,
  parameter int LEDS         = 20,
  parameter int ADDR         = 8,
  parameter int FRAME_CYCLES = 800000,
  parameter int DECAY_SHIFT  = 3,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_sample_valid,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_rdy,
  output logic [ADDR-1:0]            o_value,
  output logic                       o_send
);

  localparam int MAG_W  = SAMPLE_W - 1;
  localparam int CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int PROD_W = SAMPLE_W + ADDR;

  typedef enum logic {IDLE, WAIT_RDY} state_t;

  logic [MAG_W-1:0]  mag, mag_valid, decayed;
  logic [MAG_W-1:0]  peak_q, peak_d, snap_q, snap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick, load_q, sent_q, send;
  logic [PROD_W-1:0] prod, scaled;
  logic [ADDR-1:0]   level, value_q, value_d;
  state_t            state_q, state_d;

  // Negating only the low bits yields |x| for every negative input except the minimum.
  always_comb begin
    if (!i_sample[SAMPLE_W-1])
      mag = i_sample[MAG_W-1:0];
    else if (i_sample[MAG_W-1:0] == '0)
      mag = '1;
    else
      mag = MAG_W'(~i_sample[MAG_W-1:0] + 1'b1);
  end

  assign mag_valid = i_sample_valid ? mag : '0;
  assign tick      = (cnt_q == CNT_W'(FRAME_CYCLES - 1));
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign decayed   = peak_q - (peak_q >> DECAY_SHIFT);

  always_comb begin
    peak_d = peak_q;
    snap_d = snap_q;
    if (tick) begin
      snap_d = (mag_valid > peak_q) ? mag_valid : peak_q;
      peak_d = (mag_valid > decayed) ? mag_valid : decayed;
    end else if (mag_valid > peak_q) begin
      peak_d = mag_valid;
    end
  end

  assign prod   = PROD_W'(snap_q) * PROD_W'(LEDS + 1);
  assign scaled = prod >> MAG_W;
  assign level  = (scaled > PROD_W'(LEDS)) ? ADDR'(LEDS) : scaled[ADDR-1:0];

`ifdef VU_PEAK_HOLD_EN
  localparam int HC_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  logic [HC_W-1:0] hcnt_q, hcnt_d;

  always_comb begin
    value_d = value_q;
    hcnt_d  = hcnt_q;
    if (load_q) begin
      if (level >= value_q) begin
        value_d = level;
        hcnt_d  = HC_W'(HOLD_FRAMES);
      end else if (hcnt_q != '0) begin
        hcnt_d = hcnt_q - 1'b1;
      end else begin
        value_d = level;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hcnt_q <= '0;
    else          hcnt_q <= hcnt_d;
  end
`else
  assign value_d = load_q ? level : value_q;
`endif

  // A load arriving in the strobe cycle re-arms WAIT_RDY; sent_q keeps strobes apart.
  always_comb begin
    state_d = state_q;
    send    = 1'b0;
    if (state_q == WAIT_RDY && i_rdy && !sent_q) begin
      send    = 1'b1;
      state_d = IDLE;
    end
    if (load_q) state_d = WAIT_RDY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      peak_q  <= '0;
      snap_q  <= '0;
      load_q  <= 1'b0;
      sent_q  <= 1'b0;
      value_q <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      snap_q  <= snap_d;
      load_q  <= tick;
      sent_q  <= send;
      value_q <= value_d;
      state_q <= state_d;
    end
  end

  assign o_value = value_q;
  assign o_send  = send;

endmodule

// File: tb/tb_vu_level_meter.sv
// Directed and randomized bench for vu_level_meter against a per-cycle arithmetic reference.
module tb_vu_level_meter;
  localparam int SW = 16, LEDS = 20, ADDR = 8, FC = 100, DS = 3, HOLD = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_sample_valid = 1'b0;
  logic [SW-1:0]   i_sample = '0;
  logic            i_rdy = 1'b1;
  logic [ADDR-1:0] o_value;
  logic            o_send;

  int checks = 0, errors = 0;

  // Reference state
  int m_peak, m_cnt, m_value, m_pend, m_hcnt;
  bit m_wait, m_prev;

  vu_level_meter #(.SAMPLE_W(SW), .LEDS(LEDS), .ADDR(ADDR), .FRAME_CYCLES(FC),
                   .DECAY_SHIFT(DS), .HOLD_FRAMES(HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
    .i_rdy(i_rdy), .o_value(o_value), .o_send(o_send));

  always #5 clk = ~clk;

  function automatic int level_of(int snap);
    int l;
    l = (snap * (LEDS + 1)) / (1 << (SW - 1));
    return (l > LEDS) ? LEDS : l;
  endfunction

  function automatic int mag_of(logic [SW-1:0] s);
    int sv;
    sv = $signed(s);
    if (sv == -(1 << (SW - 1))) return (1 << (SW - 1)) - 1;
    return (sv < 0) ? -sv : sv;
  endfunction

  task automatic model_reset();
    m_peak = 0; m_cnt = 0; m_value = 0; m_pend = -1; m_hcnt = 0; m_wait = 0; m_prev = 0;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive sample, compare outputs to the model, then advance the model.
  task automatic cyc(input bit v, input logic [SW-1:0] s, output bit sent, output int val);
    int mag, snap, lv;
    bit exp_send, tick;
    i_sample_valid = v;
    i_sample       = s;
    #1;
    exp_send = m_wait && i_rdy && !m_prev;
    checks++;
    assert (o_send === exp_send) else begin
      errors++;
      $error("FAIL o_send cyc=%0d got=%b exp=%b", m_cnt, o_send, exp_send);
    end
    checks++;
    assert (o_value === ADDR'(m_value)) else begin
      errors++;
      $error("FAIL o_value cyc=%0d got=%0d exp=%0d", m_cnt, o_value, m_value);
    end
    sent = o_send;
    val  = o_value;

    mag  = v ? mag_of(s) : 0;
    tick = (m_cnt % FC) == FC - 1;
    if (exp_send) m_wait = 0;
    if (m_pend >= 0) begin
      lv = m_pend;
`ifdef VU_PEAK_HOLD_EN
      if (lv >= m_value) begin m_value = lv; m_hcnt = HOLD; end
      else if (m_hcnt > 0) m_hcnt--;
      else m_value = lv;
`else
      m_value = lv;
`endif
      m_wait = 1;
      m_pend = -1;
    end
    if (tick) begin
      snap   = (mag > m_peak) ? mag : m_peak;
      m_pend = level_of(snap);
      m_peak = m_peak - (m_peak >> DS);
      if (mag > m_peak) m_peak = mag;
    end else if (mag > m_peak) begin
      m_peak = mag;
    end
    m_prev = exp_send;
    m_cnt++;
    @(negedge clk);
  endtask

  task automatic wait_send(input int bound, output int val);
    bit s, found;
    int v;
    found = 0;
    val = -1;
    for (int i = 0; i < bound && !found; i++) begin
      cyc(1'b0, '0, s, v);
      if (s) begin found = 1; val = v; end
    end
    check("send_timeout", int'(found), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_rdy = 1'b1;
    i_sample_valid = 1'b0;
    #1;
    check("rst_send", int'(o_send), 0);
    check("rst_value", int'(o_value), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v, prev, nsend, exp2;
    bit s, reached;
    model_reset();
    exp2 = 18;
`ifdef VU_PEAK_HOLD_EN
    exp2 = 20;
`endif
    repeat (2) @(negedge clk);

    // Full-scale impulse then silence: decays monotonically to zero
    do_reset();
    cyc(1'b1, 16'h7FFF, s, v);
    wait_send(FC + 5, v);
    check("impulse_f1", v, 20);
    wait_send(FC + 5, v);
    check("impulse_f2", v, exp2);
    prev = v;
    reached = 0;
    for (int f = 0; f < 40 && !reached; f++) begin
      wait_send(FC + 5, v);
      check("decay_mono", int'(v <= prev), 1);
      prev = v;
      if (v == 0) reached = 1;
    end
    check("decay_zero", int'(reached), 1);

    // Saturation of the most negative sample, and half scale
    do_reset();
    cyc(1'b1, 16'h8000, s, v);
    wait_send(FC + 5, v);
    check("sat_8000", v, 20);
    do_reset();
    cyc(1'b1, 16'h4000, s, v);
    wait_send(FC + 5, v);
    check("half_4000", v, 10);

    // Controller busy across two ticks: single strobe with the newer level
    do_reset();
    i_rdy = 1'b0;
    cyc(1'b1, 16'h7FFF, s, v);
    nsend = 0;
    for (int i = 0; i < 2 * FC + 10; i++) begin
      cyc(1'b0, '0, s, v);
      nsend += int'(s);
    end
    check("busy_nosend", nsend, 0);
    i_rdy = 1'b1;
    wait_send(3, v);
    check("busy_level", v, exp2);
    nsend = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, s, v);
      nsend += int'(s);
    end
    check("busy_single", nsend, 0);

    // Loud sample landing exactly on the tick cycle
    do_reset();
    for (int i = 0; i < FC - 1; i++) cyc(1'b0, '0, s, v);
    cyc(1'b1, 16'h7FFF, s, v);
    wait_send(5, v);
    check("tick_sample", v, 20);

    // Reset while waiting for ready
    do_reset();
    cyc(1'b1, 16'h4000, s, v);
    i_rdy = 1'b0;
    for (int i = 0; i < FC + 5 && !m_wait; i++) cyc(1'b0, '0, s, v);
    check("reached_wait", int'(m_wait), 1);
    do_reset();
    nsend = 0;
    for (int i = 0; i < FC; i++) begin
      cyc(1'b0, '0, s, v);
      nsend += int'(s);
    end
    check("post_rst_nosend", nsend, 0);
    wait_send(5, v);
    check("post_rst_level", v, 0);

    // Randomized samples and ready toggling
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) i_rdy = ~i_rdy;
      case ($urandom_range(0, 7))
        0:       cyc(1'b1, 16'h8000, s, v);
        1, 2:    cyc(1'b1, SW'($urandom), s, v);
        3:       cyc(1'b1, SW'($urandom_range(0, 3000)), s, v);
        default: cyc(1'b0, SW'($urandom), s, v);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
